// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the set-associative D-cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_SB  = 1'b1
  } req_e;

  // Tags are stored zero-extended to a fixed width so the struct needs no parameters.
  localparam int MAX_TAG_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } tag_entry_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction

  // Way index width, kept at least one bit so a direct-mapped build still has a legal vector.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Per-set age-counter LRU: touched way becomes age 0, the oldest way is the victim.
module sa_cache_lru
  import dcache_pkg::*;
#(
  parameter  int SETS  = 4,
  parameter  int WAYS  = 2,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] victim_idx,
  output logic [WAY_W-1:0] victim_way
);

  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic [WAY_W-1:0] best_age;

  // Age update: ways at or below the touched way's age get older (saturating), so the all-zero
  // reset state settles into a proper ordering once every way has been touched.
  always_comb begin
    age_d = age_q;
    if (touch_valid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w == int'(touch_way)) begin
          age_d[touch_idx][w] = '0;
        end else if ((age_q[touch_idx][w] <= age_q[touch_idx][touch_way]) &&
                     (age_q[touch_idx][w] != AGE_MAX)) begin
          age_d[touch_idx][w] = age_q[touch_idx][w] + 1'b1;
        end
      end
    end
  end

  // Victim is the oldest way of the set; ties go to the lowest index.
  always_comb begin
    victim_way = '0;
    best_age   = age_q[victim_idx][0];
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[victim_idx][w] > best_age) begin
        best_age   = age_q[victim_idx][w];
        victim_way = WAY_W'(w);
      end
    end
  end

  // Age registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= '0;
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/sa_dcache_fsm.sv
// Set-associative D-cache controller: CPU/store-buffer arbitration, write-back and line fill.
// Optional macro SA_DCACHE_PERF_CNT_EN adds saturating hit/miss/write-back counters.
module sa_dcache_fsm
  import dcache_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int SETS       = 4,
  parameter  int WAYS       = 2,
  parameter  int LINE_WORDS = 4,
  localparam int LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_res_ready,
  output logic [31:0]       cpu_res_data,
  input  logic              sb_drain_valid,
  input  logic [ADDR_W-1:0] sb_drain_addr,
  input  logic [31:0]       sb_drain_data,
  output logic              sb_drain_done,
  input  logic              force_drain,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_resp_ready,
  input  logic [LINE_W-1:0] mem_resp_data
`ifdef SA_DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_writebacks
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int WSEL_W = OFF_W - 2;

  state_e state_q, state_d;
  req_e   req_id_q, req_id_d;
  logic              req_rw_q, req_rw_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic [WAY_W-1:0]  victim_way_q, victim_way_d;
  logic [TAG_W-1:0]  victim_tag_q, victim_tag_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_rw_q, mem_req_rw_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [LINE_W-1:0] mem_req_data_q, mem_req_data_d;
  tag_entry_t        tags_q [SETS][WAYS];
  tag_entry_t        tags_d [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];

  logic              data_we;
  logic [IDX_W-1:0]  data_idx;
  logic [WAY_W-1:0]  data_way;
  logic [LINE_W-1:0] data_line;
  logic              touch_valid;
  logic [IDX_W-1:0]  touch_idx;
  logic [WAY_W-1:0]  touch_way;
  logic [WAY_W-1:0]  lru_victim, invalid_way, victim_way;
  logic              have_invalid, victim_dirty;
  logic              req_hit, sb_hit;
  logic [WAY_W-1:0]  req_hit_way, sb_hit_way;

  logic [IDX_W-1:0]  req_idx, sb_idx;
  logic [TAG_W-1:0]  req_tag, sb_tag;
  logic [WSEL_W-1:0] req_wsel, sb_wsel;
  logic              unused_addr_bits;

  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_wsel = req_addr_q[2 +: WSEL_W];
  assign sb_idx   = sb_drain_addr[OFF_W +: IDX_W];
  assign sb_tag   = sb_drain_addr[ADDR_W-1 -: TAG_W];
  assign sb_wsel  = sb_drain_addr[2 +: WSEL_W];
  assign unused_addr_bits = ^req_addr_q[1:0];

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;

  sa_cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clock       (clock),
    .reset       (reset),
    .touch_valid (touch_valid),
    .touch_idx   (touch_idx),
    .touch_way   (touch_way),
    .victim_idx  (req_idx),
    .victim_way  (lru_victim)
  );

  // Tag lookups: latched request for COMPARE, live drain address for the IDLE fast path.
  always_comb begin
    req_hit     = 1'b0;
    req_hit_way = '0;
    sb_hit      = 1'b0;
    sb_hit_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tags_q[req_idx][w].valid && (tags_q[req_idx][w].tag == MAX_TAG_W'(req_tag))) begin
        req_hit     = 1'b1;
        req_hit_way = WAY_W'(w);
      end
      if (tags_q[sb_idx][w].valid && (tags_q[sb_idx][w].tag == MAX_TAG_W'(sb_tag))) begin
        sb_hit     = 1'b1;
        sb_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way first, otherwise whatever the LRU names.
  always_comb begin
    have_invalid = 1'b0;
    invalid_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!tags_q[req_idx][w].valid) begin
        have_invalid = 1'b1;
        invalid_way  = WAY_W'(w);
      end
    end
    victim_way   = have_invalid ? invalid_way : lru_victim;
    victim_dirty = tags_q[req_idx][victim_way].valid && tags_q[req_idx][victim_way].dirty;
  end

  // Next-state, completion pulses, array updates and memory request for the controller.
  always_comb begin
    state_d         = state_q;
    req_id_d        = req_id_q;
    req_rw_d        = req_rw_q;
    req_addr_d      = req_addr_q;
    req_data_d      = req_data_q;
    victim_way_d    = victim_way_q;
    victim_tag_d    = victim_tag_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_rw_d    = mem_req_rw_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    tags_d          = tags_q;
    data_we         = 1'b0;
    data_idx        = req_idx;
    data_way        = req_hit_way;
    data_line       = data_q[req_idx][req_hit_way];
    touch_valid     = 1'b0;
    touch_idx       = req_idx;
    touch_way       = req_hit_way;
    cpu_res_ready   = 1'b0;
    cpu_res_data    = '0;
    sb_drain_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid && !force_drain) begin
          req_id_d   = REQ_CPU;
          req_rw_d   = cpu_req_rw;
          req_addr_d = cpu_req_addr;
          req_data_d = '0;
          state_d    = COMPARE;
        end else if (sb_drain_valid) begin
          if (sb_hit) begin
            data_we   = 1'b1;
            data_idx  = sb_idx;
            data_way  = sb_hit_way;
            data_line = data_q[sb_idx][sb_hit_way];
            data_line[32*int'(sb_wsel) +: 32] = sb_drain_data;
            tags_d[sb_idx][sb_hit_way].dirty = 1'b1;
            touch_valid   = 1'b1;
            touch_idx     = sb_idx;
            touch_way     = sb_hit_way;
            sb_drain_done = 1'b1;
          end else begin
            req_id_d   = REQ_SB;
            req_rw_d   = 1'b1;
            req_addr_d = sb_drain_addr;
            req_data_d = sb_drain_data;
            state_d    = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (req_hit) begin
          touch_valid = 1'b1;
          state_d     = IDLE;
          if (req_id_q == REQ_CPU) begin
            cpu_res_ready = 1'b1;
            if (req_rw_q) begin
              tags_d[req_idx][req_hit_way].dirty = 1'b1;
            end else begin
              cpu_res_data = data_q[req_idx][req_hit_way][32*int'(req_wsel) +: 32];
            end
          end else begin
            data_we = 1'b1;
            data_line[32*int'(req_wsel) +: 32] = req_data_q;
            tags_d[req_idx][req_hit_way].dirty = 1'b1;
            sb_drain_done = 1'b1;
          end
        end else begin
          victim_way_d    = victim_way;
          mem_req_valid_d = 1'b1;
          if (victim_dirty) begin
            victim_tag_d   = tags_q[req_idx][victim_way].tag[TAG_W-1:0];
            mem_req_rw_d   = 1'b1;
            mem_req_addr_d = {tags_q[req_idx][victim_way].tag[TAG_W-1:0], req_idx, {OFF_W{1'b0}}};
            mem_req_data_d = data_q[req_idx][victim_way];
            state_d        = WRITE_BACK;
          end else begin
            mem_req_rw_d   = 1'b0;
            mem_req_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
            state_d        = ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        if (mem_resp_ready) begin
          tags_d[req_idx][victim_way_q].dirty = 1'b0;
          mem_req_rw_d   = 1'b0;
          mem_req_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          mem_req_data_d = '0;
          state_d        = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_resp_ready) begin
          data_we   = 1'b1;
          data_way  = victim_way_q;
          data_line = mem_resp_data;
          tags_d[req_idx][victim_way_q].valid = 1'b1;
          tags_d[req_idx][victim_way_q].dirty = 1'b0;
          tags_d[req_idx][victim_way_q].tag   = MAX_TAG_W'(req_tag);
          mem_req_valid_d = 1'b0;
          mem_req_addr_d  = '0;
          state_d         = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cpu_res_ready = 1'b0;
      sb_drain_done = 1'b0;
      data_we       = 1'b0;
      touch_valid   = 1'b0;
    end
  end

  // Control state, latched request, memory request and tag array registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      req_id_q        <= REQ_CPU;
      req_rw_q        <= 1'b0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      victim_way_q    <= '0;
      victim_tag_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tags_q[s][w] <= '0;
        end
      end
    end else begin
      state_q         <= state_d;
      req_id_q        <= req_id_d;
      req_rw_q        <= req_rw_d;
      req_addr_q      <= req_addr_d;
      req_data_q      <= req_data_d;
      victim_way_q    <= victim_way_d;
      victim_tag_q    <= victim_tag_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_rw_q    <= mem_req_rw_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      tags_q          <= tags_d;
    end
  end

  // Line data storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (data_we) begin
      data_q[data_idx][data_way] <= data_line;
    end
  end

`ifdef SA_DCACHE_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;
  logic [31:0] perf_wb_q, perf_wb_d;

  // Saturating event counters sampled on COMPARE outcomes.
  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    perf_wb_d     = perf_wb_q;
    if (state_q == COMPARE) begin
      if (req_hit) begin
        if (perf_hits_q != 32'hFFFF_FFFF) perf_hits_d = perf_hits_q + 32'd1;
      end else begin
        if (perf_misses_q != 32'hFFFF_FFFF) perf_misses_d = perf_misses_q + 32'd1;
        if (victim_dirty && (perf_wb_q != 32'hFFFF_FFFF)) perf_wb_d = perf_wb_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
      perf_wb_q     <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
      perf_wb_q     <= perf_wb_d;
    end
  end

  assign perf_hits       = perf_hits_q;
  assign perf_misses     = perf_misses_q;
  assign perf_writebacks = perf_wb_q;
`endif

endmodule

// File: tb/tb_sa_dcache_fsm.sv
// Directed self-checking bench for sa_dcache_fsm (SETS=4, WAYS=2, LINE_WORDS=4).
module tb_sa_dcache_fsm;

  logic         clock;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_rw;
  logic [31:0]  cpu_req_addr;
  logic         cpu_res_ready;
  logic [31:0]  cpu_res_data;
  logic         sb_drain_valid;
  logic [31:0]  sb_drain_addr;
  logic [31:0]  sb_drain_data;
  logic         sb_drain_done;
  logic         force_drain;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_ready;
  logic [127:0] mem_resp_data;
`ifdef SA_DCACHE_PERF_CNT_EN
  logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

  localparam logic [127:0] FILL_A = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_44332211;
  localparam logic [127:0] FILL_B = 128'h0B0B0B03_0B0B0B02_0B0B0B01_0B0B0B00;
  localparam logic [127:0] FILL_C = 128'h0C0C0C03_0C0C0C02_0C0C0C01_0C0C0C00;
  localparam logic [127:0] FILL_D = 128'h0D0D0D03_0D0D0D02_0D0D0D01_0D0D0D00;
  localparam logic [127:0] FILL_E = 128'h0E0E0E03_0E0E0E02_0E0E0E01_0E0E0E00;

  int          checks = 0;
  int          errors = 0;
  int          gotLat;
  int          fillRespCycle;
  int          wbSeen;
  int          fillSeen;
  logic [31:0]  gotData;
  logic [31:0]  wbAddr;
  logic [127:0] wbData;
  logic [31:0]  fillAddr;

  sa_dcache_fsm #(
    .ADDR_W     (32),
    .SETS       (4),
    .WAYS       (2),
    .LINE_WORDS (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_rw     (cpu_req_rw),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_res_ready  (cpu_res_ready),
    .cpu_res_data   (cpu_res_data),
    .sb_drain_valid (sb_drain_valid),
    .sb_drain_addr  (sb_drain_addr),
    .sb_drain_data  (sb_drain_data),
    .sb_drain_done  (sb_drain_done),
    .force_drain    (force_drain),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data)
`ifdef SA_DCACHE_PERF_CNT_EN
    ,
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses),
    .perf_writebacks (perf_writebacks)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One CPU access; the bench acts as memory, answering each request after waitCycles cycles.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [127:0] fill,
                               input int waitCycles);
    int held;
    held          = 0;
    gotLat        = -1;
    gotData       = 32'h0;
    wbSeen        = 0;
    fillSeen      = 0;
    fillRespCycle = -1;
    wbAddr        = 32'h0;
    wbData        = '0;
    fillAddr      = 32'h0;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    tick();
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 32'hFFFF_FFFC;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (cpu_res_ready) begin
        gotLat  = cyc;
        gotData = cpu_res_data;
        break;
      end
      if (mem_req_valid) begin
        if (held < waitCycles) begin
          held++;
        end else begin
          if (mem_req_rw) begin
            wbSeen++;
            wbAddr = mem_req_addr;
            wbData = mem_req_data;
          end else begin
            fillSeen++;
            fillAddr      = mem_req_addr;
            mem_resp_data = fill;
            fillRespCycle = cyc;
          end
          mem_resp_ready = 1'b1;
          held = 0;
        end
      end
      tick();
      mem_resp_ready = 1'b0;
    end
    tick();
  endtask

  // Store-buffer drain expected to hit, with completion in the acceptance cycle.
  task automatic drainHit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    sb_drain_valid = 1'b1;
    sb_drain_addr  = addr;
    sb_drain_data  = data;
    #1;
    checkOutput(tag, 128'(sb_drain_done), 128'(1'b1));
    tick();
    sb_drain_valid = 1'b0;
    sb_drain_addr  = 32'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_rw     = 1'b0;
    cpu_req_addr   = 32'h0;
    sb_drain_valid = 1'b0;
    sb_drain_addr  = 32'h0;
    sb_drain_data  = 32'h0;
    force_drain    = 1'b0;
    mem_resp_ready = 1'b0;
    mem_resp_data  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_ready", 128'(cpu_res_ready), 128'(1'b0));
    checkOutput("rst_done", 128'(sb_drain_done), 128'(1'b0));
    checkOutput("rst_memv", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("rst_mema", 128'(mem_req_addr), 128'(32'h0));

    // Cold load with a delayed fill, then a hit.
    applyStimulus(1'b0, 32'h100, FILL_A, 2);
    checkOutput("s1_fills", 128'(fillSeen), 128'(1));
    checkOutput("s1_wbs", 128'(wbSeen), 128'(0));
    checkOutput("s1_faddr", 128'(fillAddr), 128'(32'h100));
    checkOutput("s1_data", 128'(gotData), 128'(32'h44332211));
    checkOutput("s1_lat", 128'(gotLat), 128'(fillRespCycle + 1));
    applyStimulus(1'b0, 32'h100, FILL_A, 0);
    checkOutput("s1_hitlat", 128'(gotLat), 128'(1));
    checkOutput("s1_hitfill", 128'(fillSeen), 128'(0));
    checkOutput("s1_hitdata", 128'(gotData), 128'(32'h44332211));
    applyStimulus(1'b0, 32'h10C, FILL_A, 0);
    checkOutput("s1_w3data", 128'(gotData), 128'(32'hCCCCCCCC));

    // Store hit, drain, reload.
    applyStimulus(1'b1, 32'h104, FILL_A, 0);
    checkOutput("s2_stlat", 128'(gotLat), 128'(1));
    checkOutput("s2_stmem", 128'(fillSeen + wbSeen), 128'(0));
    drainHit("s2_done", 32'h104, 32'hDEADBEEF);
    #1;
    checkOutput("s2_donepulse", 128'(sb_drain_done), 128'(1'b0));
    applyStimulus(1'b0, 32'h104, FILL_A, 0);
    checkOutput("s2_ldata", 128'(gotData), 128'(32'hDEADBEEF));

    // Two-way conflict in set 0.
    applyStimulus(1'b0, 32'h140, FILL_B, 0);
    checkOutput("s3_faddr", 128'(fillAddr), 128'(32'h140));
    checkOutput("s3_data", 128'(gotData), 128'(32'h0B0B0B00));
    drainHit("s3_done", 32'h100, 32'h12345678);
    applyStimulus(1'b0, 32'h180, FILL_C, 1);
    checkOutput("s3_evict_wb", 128'(wbSeen), 128'(0));
    checkOutput("s3_faddr2", 128'(fillAddr), 128'(32'h180));
    checkOutput("s3_data2", 128'(gotData), 128'(32'h0C0C0C00));
    applyStimulus(1'b0, 32'h100, FILL_A, 0);
    checkOutput("s3_hitlat", 128'(gotLat), 128'(1));
    checkOutput("s3_hitdata", 128'(gotData), 128'(32'h12345678));

    // Make 0x180 most recent so the dirty 0x100 line is the victim.
    applyStimulus(1'b0, 32'h180, FILL_C, 0);
    checkOutput("s4_hitlat", 128'(gotLat), 128'(1));
    applyStimulus(1'b0, 32'h1C0, FILL_D, 1);
    checkOutput("s4_wbs", 128'(wbSeen), 128'(1));
    checkOutput("s4_wbaddr", 128'(wbAddr), 128'(32'h100));
    checkOutput("s4_wbdata", wbData, 128'hCCCCCCCC_BBBBBBBB_DEADBEEF_12345678);
    checkOutput("s4_faddr", 128'(fillAddr), 128'(32'h1C0));
    checkOutput("s4_data", 128'(gotData), 128'(32'h0D0D0D00));
    checkOutput("s4_lat", 128'(gotLat), 128'(fillRespCycle + 1));
    applyStimulus(1'b0, 32'h100, FILL_A, 0);
    checkOutput("s4_refill", 128'(fillSeen), 128'(1));
    checkOutput("s4_refill_wb", 128'(wbSeen), 128'(0));

    // CPU and SB together without force_drain: CPU first.
    cpu_req_valid  = 1'b1;
    cpu_req_rw     = 1'b0;
    cpu_req_addr   = 32'h104;
    sb_drain_valid = 1'b1;
    sb_drain_addr  = 32'h108;
    sb_drain_data  = 32'h55AA55AA;
    #1;
    checkOutput("s5_sbwait", 128'(sb_drain_done), 128'(1'b0));
    tick();
    cpu_req_valid = 1'b0;
    #1;
    checkOutput("s5_cpuready", 128'(cpu_res_ready), 128'(1'b1));
    checkOutput("s5_cpudata", 128'(cpu_res_data), 128'(32'hAAAAAAAA));
    checkOutput("s5_busydone", 128'(sb_drain_done), 128'(1'b0));
    tick();
    #1;
    checkOutput("s5_sbdone", 128'(sb_drain_done), 128'(1'b1));
    tick();
    sb_drain_valid = 1'b0;
    applyStimulus(1'b0, 32'h108, FILL_A, 0);
    checkOutput("s5_drained", 128'(gotData), 128'(32'h55AA55AA));

    // Same with force_drain: drain completes before the CPU load.
    cpu_req_valid  = 1'b1;
    cpu_req_rw     = 1'b0;
    cpu_req_addr   = 32'h10C;
    sb_drain_valid = 1'b1;
    sb_drain_addr  = 32'h10C;
    sb_drain_data  = 32'h77777777;
    force_drain    = 1'b1;
    #1;
    checkOutput("s5f_done", 128'(sb_drain_done), 128'(1'b1));
    checkOutput("s5f_noready", 128'(cpu_res_ready), 128'(1'b0));
    tick();
    sb_drain_valid = 1'b0;
    force_drain    = 1'b0;
    #1;
    checkOutput("s5f_accept", 128'(cpu_res_ready), 128'(1'b0));
    tick();
    cpu_req_valid = 1'b0;
    #1;
    checkOutput("s5f_ready", 128'(cpu_res_ready), 128'(1'b1));
    checkOutput("s5f_data", 128'(cpu_res_data), 128'(32'h77777777));
    tick();

    // Reset while a fill is outstanding.
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 32'h210;
    tick();
    cpu_req_valid = 1'b0;
    tick();
    #1;
    checkOutput("s6_memv", 128'(mem_req_valid), 128'(1'b1));
    checkOutput("s6_memaddr", 128'(mem_req_addr), 128'(32'h210));
    checkOutput("s6_memrw", 128'(mem_req_rw), 128'(1'b0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("s6_memv_off", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("s6_noready", 128'(cpu_res_ready), 128'(1'b0));
    checkOutput("s6_nodone", 128'(sb_drain_done), 128'(1'b0));
    applyStimulus(1'b0, 32'h100, FILL_E, 0);
    checkOutput("s6_miss", 128'(fillSeen), 128'(1));
    checkOutput("s6_nowb", 128'(wbSeen), 128'(0));
    checkOutput("s6_data", 128'(gotData), 128'(32'h0E0E0E00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
